// File: rtl/haze_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : haze_load_pkg
// Description : Shared definitions for the haze-cpu load unit: funct3 load
//               encodings, the load FSM state type and the alignment and
//               legality helpers used at request acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
package haze_load_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } t_LoadState;

    // funct3 011, 110 and 111 have no load meaning.
    function automatic logic f_IsIllegal(input logic [2:0] funct3);
        case (funct3)
            LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: return 1'b0;
            default:                                       return 1'b1;
        endcase
    endfunction

    // Byte loads are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic f_IsMisaligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        case (funct3)
            LOAD_LH, LOAD_LHU: return addr_lo[0];
            LOAD_LW:           return (addr_lo != 2'b00);
            default:           return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/extender_NtoM.sv
`default_nettype none
// ============================================================================
// Module      : extender_NtoM
// Description : Widens an N-bit value to M bits by sign or zero extension.
// Ports       : i_Data          - N-bit input value
//               i_ExtensionType - 1: sign extend, 0: zero extend
//               o_Data          - M-bit extended value
// Revision    : 1.0 - initial release
// ============================================================================
module extender_NtoM #(
    parameter int p_N = 8,
    parameter int p_M = 32
) (
    input  logic [p_N-1:0] i_Data,
    input  logic           i_ExtensionType,
    output logic [p_M-1:0] o_Data
);

    assign o_Data = {{(p_M - p_N){i_ExtensionType & i_Data[p_N-1]}}, i_Data};

endmodule
`default_nettype wire

// File: rtl/load_lane_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_lane_extract
// Description : Selects the byte, halfword or word lane addressed by a load
//               from a little-endian memory word and extends it to 32 bits.
// Ports       : word    - 32-bit word returned by data memory
//               addr_lo - byte offset of the load within the word
//               funct3  - load kind (size in [1:0], unsigned flag in [2])
//               result  - extended 32-bit load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_lane_extract
    import haze_load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] byte_ext;
    logic [31:0] half_ext;
    logic        sign_ext;

    // funct3[2]=0 means a signed load.
    assign sign_ext  = ~funct3[2];
    assign byte_lane = word[8*addr_lo +: 8];
    assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    extender_NtoM #(.p_N(8), .p_M(32)) u_ext_byte (
        .i_Data          (byte_lane),
        .i_ExtensionType (sign_ext),
        .o_Data          (byte_ext)
    );

    extender_NtoM #(.p_N(16), .p_M(32)) u_ext_half (
        .i_Data          (half_lane),
        .i_ExtensionType (sign_ext),
        .o_Data          (half_ext)
    );

    always_comb begin
        result = word;
        case (funct3[1:0])
            2'b00:   result = byte_ext;
            2'b01:   result = half_ext;
            default: result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Memory-stage load unit. Accepts one load at a time, issues a
//               word-aligned read, extracts and extends the addressed lane and
//               presents the registered result over a valid/ready handshake.
// Ports       : i_CLK, i_RSTn            - clock, async active-low reset
//               i_Valid/o_Ready          - request handshake
//               i_Address, i_Funct3      - byte address and load kind
//               o_MemReq, o_MemAddress   - word-aligned memory read request
//               i_MemAck, i_MemData      - memory read completion and data
//               o_Valid/i_Ready          - result handshake
//               o_Data, o_Fault          - load result and fault flag
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
    import haze_load_pkg::*;
#(
    parameter int p_ADDR_WIDTH = 32,
    parameter int p_XLEN       = 32
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    input  logic [p_ADDR_WIDTH-1:0] i_Address,
    input  logic [2:0]              i_Funct3,
    output logic                    o_MemReq,
    output logic [p_ADDR_WIDTH-1:0] o_MemAddress,
    input  logic                    i_MemAck,
    input  logic [p_XLEN-1:0]       i_MemData,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [p_XLEN-1:0]       o_Data,
    output logic                    o_Fault
);

    t_LoadState  state;
    logic [1:0]  addr_lo;
    logic [2:0]  funct3;
    logic [31:0] lane_result;
    logic        req_fault;

    assign req_fault = f_IsIllegal(i_Funct3) | f_IsMisaligned(i_Funct3, i_Address[1:0]);

    load_lane_extract u_lane (
        .word    (i_MemData),
        .addr_lo (addr_lo),
        .funct3  (funct3),
        .result  (lane_result)
    );

    // Every output is a register so nothing combinational reaches the ports
    // from i_Valid or i_MemAck.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state        <= IDLE;
            addr_lo      <= 2'b00;
            funct3       <= 3'b000;
            o_Ready      <= 1'b1;
            o_MemReq     <= 1'b0;
            o_MemAddress <= '0;
            o_Valid      <= 1'b0;
            o_Data       <= '0;
            o_Fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        addr_lo <= i_Address[1:0];
                        funct3  <= i_Funct3;
                        o_Ready <= 1'b0;
                        if (req_fault) begin
                            // Faults skip memory entirely and report a zero result.
                            state   <= RESP;
                            o_Valid <= 1'b1;
                            o_Fault <= 1'b1;
                            o_Data  <= '0;
                        end else begin
                            state        <= REQ;
                            o_MemReq     <= 1'b1;
                            o_MemAddress <= {i_Address[p_ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (i_MemAck) begin
                        state    <= RESP;
                        o_MemReq <= 1'b0;
                        o_Valid  <= 1'b1;
                        o_Fault  <= 1'b0;
                        o_Data   <= lane_result;
                    end
                end
                RESP: begin
                    if (i_Ready) begin
                        state   <= IDLE;
                        o_Valid <= 1'b0;
                        o_Ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_Ready  <= 1'b1;
                    o_MemReq <= 1'b0;
                    o_Valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Self-checking bench for load_unit: table-driven loads against
//               a one-word memory model, plus hand-written stall, backpressure
//               and mid-request reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit;

    localparam logic [31:0] MEM_WORD = 32'h8070F0A5;
    localparam logic [31:0] MEM_BASE = 32'h00000100;

    logic        i_CLK = 1'b0;
    logic        i_RSTn = 1'b0;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [31:0] i_Address = '0;
    logic [2:0]  i_Funct3 = '0;
    logic        o_MemReq;
    logic [31:0] o_MemAddress;
    logic        i_MemAck = 1'b0;
    logic [31:0] i_MemData = '0;
    logic        o_Valid;
    logic        i_Ready = 1'b0;
    logic [31:0] o_Data;
    logic        o_Fault;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries: {fault, data}.
    logic [32:0] sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] exp_data;
        logic        exp_fault;
    } t_vec;

    t_vec vecs[16];

    load_unit #(.p_ADDR_WIDTH(32), .p_XLEN(32)) dut (
        .i_CLK        (i_CLK),
        .i_RSTn       (i_RSTn),
        .i_Valid      (i_Valid),
        .o_Ready      (o_Ready),
        .i_Address    (i_Address),
        .i_Funct3     (i_Funct3),
        .o_MemReq     (o_MemReq),
        .o_MemAddress (o_MemAddress),
        .i_MemAck     (i_MemAck),
        .i_MemData    (i_MemData),
        .o_Valid      (o_Valid),
        .i_Ready      (i_Ready),
        .o_Data       (o_Data),
        .o_Fault      (o_Fault)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Memory model: only the word at MEM_BASE holds known data.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return (a == MEM_BASE) ? MEM_WORD : 32'hDEADBEEF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},   {31'd0, o_Ready},  32'd1);
        chk({tag, "_memreq"},  {31'd0, o_MemReq}, 32'd0);
        chk({tag, "_memaddr"}, o_MemAddress,      32'd0);
        chk({tag, "_valid"},   {31'd0, o_Valid},  32'd0);
        chk({tag, "_data"},    o_Data,            32'd0);
        chk({tag, "_fault"},   {31'd0, o_Fault},  32'd0);
    endtask

    // One complete load: accept, optional memory wait, optional backpressure,
    // then the writeback handshake where the scoreboard is popped.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] exp_data, input logic exp_fault,
                            input int ack_wait, input int ready_wait);
        logic [32:0] expv;
        int          budget;
        i_Valid   = 1'b1;
        i_Address = addr;
        i_Funct3  = f3;
        chk("ready_idle", {31'd0, o_Ready}, 32'd1);
        @(posedge i_CLK); #1;
        i_Valid   = 1'b0;
        i_Address = $urandom;
        i_Funct3  = 3'($urandom);
        sb.push_back({exp_fault, exp_data});
        chk("ready_busy", {31'd0, o_Ready}, 32'd0);
        if (!exp_fault) begin
            chk("memreq_c1", {31'd0, o_MemReq}, 32'd1);
            chk("memaddr",   o_MemAddress, {addr[31:2], 2'b00});
            chk("valid_c1",  {31'd0, o_Valid}, 32'd0);
            for (int i = 0; i < ack_wait; i++) begin
                @(posedge i_CLK); #1;
                chk("memreq_hold",  {31'd0, o_MemReq}, 32'd1);
                chk("memaddr_hold", o_MemAddress, {addr[31:2], 2'b00});
                chk("ready_wait",   {31'd0, o_Ready}, 32'd0);
                chk("valid_wait",   {31'd0, o_Valid}, 32'd0);
            end
            i_MemAck  = 1'b1;
            i_MemData = mem_read(o_MemAddress);
            @(posedge i_CLK); #1;
            i_MemAck  = 1'b0;
            i_MemData = $urandom;
        end
        chk("memreq_off", {31'd0, o_MemReq}, 32'd0);
        chk("valid_on",   {31'd0, o_Valid},  32'd1);
        for (int i = 0; i < ready_wait; i++) begin
            @(posedge i_CLK); #1;
            chk("data_hold",  o_Data, exp_data);
            chk("fault_hold", {31'd0, o_Fault}, {31'd0, exp_fault});
            chk("valid_hold", {31'd0, o_Valid}, 32'd1);
            chk("ready_bp",   {31'd0, o_Ready}, 32'd0);
        end
        i_Ready = 1'b1;
        budget  = 0;
        while (!o_Valid && budget < 10) begin
            @(posedge i_CLK); #1;
            budget++;
        end
        if (!o_Valid) chk("valid_timeout", 32'd0, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            expv = sb.pop_front();
            chk("data",  o_Data, expv[31:0]);
            chk("fault", {31'd0, o_Fault}, {31'd0, expv[32]});
        end
        @(posedge i_CLK); #1;
        i_Ready = 1'b0;
        chk("valid_done", {31'd0, o_Valid}, 32'd0);
        chk("ready_done", {31'd0, o_Ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h101, 3'b000, 32'hFFFFFFF0, 1'b0};
        vecs[1]  = '{32'h103, 3'b100, 32'h00000080, 1'b0};
        vecs[2]  = '{32'h102, 3'b001, 32'hFFFF8070, 1'b0};
        vecs[3]  = '{32'h100, 3'b101, 32'h0000F0A5, 1'b0};
        vecs[4]  = '{32'h100, 3'b010, 32'h8070F0A5, 1'b0};
        vecs[5]  = '{32'h100, 3'b000, 32'hFFFFFFA5, 1'b0};
        vecs[6]  = '{32'h102, 3'b100, 32'h00000070, 1'b0};
        vecs[7]  = '{32'h100, 3'b001, 32'hFFFFF0A5, 1'b0};
        vecs[8]  = '{32'h102, 3'b101, 32'h00008070, 1'b0};
        vecs[9]  = '{32'h103, 3'b000, 32'hFFFFFF80, 1'b0};
        vecs[10] = '{32'h102, 3'b010, 32'h00000000, 1'b1};
        vecs[11] = '{32'h101, 3'b001, 32'h00000000, 1'b1};
        vecs[12] = '{32'h100, 3'b011, 32'h00000000, 1'b1};
        vecs[13] = '{32'h103, 3'b101, 32'h00000000, 1'b1};
        vecs[14] = '{32'h101, 3'b010, 32'h00000000, 1'b1};
        vecs[15] = '{32'h100, 3'b111, 32'h00000000, 1'b1};

        #12;
        check_reset_outputs("rst");
        i_RSTn = 1'b1;
        @(posedge i_CLK); #1;
        check_reset_outputs("post_rst");

        for (int i = 0; i < 16; i++)
            run_load(vecs[i].addr, vecs[i].f3, vecs[i].exp_data, vecs[i].exp_fault, 0, 0);

        // Slow memory followed by writeback backpressure.
        run_load(32'h102, 3'b001, 32'hFFFF8070, 1'b0, 3, 3);
        // Fault result held under backpressure.
        run_load(32'h100, 3'b110, 32'h00000000, 1'b1, 0, 2);

        // Reset asserted mid-request, then a late acknowledge.
        i_Valid   = 1'b1;
        i_Address = 32'h101;
        i_Funct3  = 3'b000;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        chk("rstreq_memreq", {31'd0, o_MemReq}, 32'd1);
        @(posedge i_CLK); #2;
        i_RSTn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge i_CLK); #1;
        i_RSTn    = 1'b1;
        i_MemAck  = 1'b1;
        i_MemData = MEM_WORD;
        @(posedge i_CLK); #1;
        i_MemAck = 1'b0;
        check_reset_outputs("late_ack");
        @(posedge i_CLK); #1;
        check_reset_outputs("late_ack2");
        run_load(32'h100, 3'b100, 32'h000000A5, 1'b0, 0, 0);

        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
